// File: rtl/enemy_move_scheduler.sv
// enemy_move_scheduler
//   Runs one round-robin round of random-walk steps every P qualifying VGA
//   frames. P = DIV_BASE - level. The round starts at start_ptr, and
//   start_ptr rotates by one after each completed round. Each alive enemy
//   gets a one-cycle timer_done pulse and a 4-bit direction taken from a
//   16-bit Galois LFSR.
//
// Ports
//   CLK, RESETn    clock; asynchronous active-low reset
//   frame_start    one-cycle pulse per VGA frame
//   enable         game running (the LFSR advances only while high)
//   freeze         hold all enemies
//   level[1:0]     speed level 0..3
//   alive[N-1:0]   enemy k present
//   timer_done     registered one-hot step pulse
//   random[3:0]    registered direction for the pulsed enemy; holds otherwise
//   round_active   FSM not idle
//   round_count    completed rounds (wraps)
module enemy_move_scheduler #(
   parameter int unsigned N_ENEMIES = 4,
   parameter int unsigned DIV_BASE  = 6,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                 CLK,
   input  logic                 RESETn,
   input  logic                 frame_start,
   input  logic                 enable,
   input  logic                 freeze,
   input  logic [1:0]           level,
   input  logic [N_ENEMIES-1:0] alive,
   output logic [N_ENEMIES-1:0] timer_done,
   output logic [3:0]           random,
   output logic                 round_active,
   output logic [7:0]           round_count
);

   localparam int unsigned    IW       = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1;
   localparam logic [IW-1:0]  LAST     = IW'(N_ENEMIES - 1);
   localparam logic [IW-1:0]  ONE      = IW'(1);
   localparam logic [15:0]    SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [15:0]    TAPS     = 16'hB400;

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t                 state, state_nxt;
   logic [IW-1:0]          idx, idx_nxt;
   logic [IW-1:0]          slot, slot_nxt;
   logic [IW-1:0]          start_ptr, start_ptr_nxt;
   logic [2:0]             frame_cnt, frame_cnt_nxt;
   logic [15:0]            lfsr, lfsr_nxt;
   logic [N_ENEMIES-1:0]   timer_done_nxt;
   logic [3:0]             random_nxt;
   logic [7:0]             round_count_nxt;
   logic [2:0]             period_m1;
   logic                   abort;

   // Unsigned 3-bit period arithmetic; DIV_BASE >= 4 keeps P >= 1.
   assign period_m1    = 3'(DIV_BASE) - {1'b0, level} - 3'd1;
   assign abort        = !enable || freeze;
   assign round_active = (state != IDLE);

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state       <= IDLE;
         idx         <= '0;
         slot        <= '0;
         start_ptr   <= '0;
         frame_cnt   <= '0;
         lfsr        <= SEED_EFF;
         timer_done  <= '0;
         random      <= '0;
         round_count <= '0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         slot        <= slot_nxt;
         start_ptr   <= start_ptr_nxt;
         frame_cnt   <= frame_cnt_nxt;
         lfsr        <= lfsr_nxt;
         timer_done  <= timer_done_nxt;
         random      <= random_nxt;
         round_count <= round_count_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      idx_nxt         = idx;
      slot_nxt        = slot;
      start_ptr_nxt   = start_ptr;
      frame_cnt_nxt   = frame_cnt;
      timer_done_nxt  = '0;
      random_nxt      = random;
      round_count_nxt = round_count;

      lfsr_nxt = lfsr;
      if (enable)
         lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);

      case (state)
         IDLE: begin
            if (frame_start && enable && !freeze) begin
               if (frame_cnt >= period_m1) begin
                  frame_cnt_nxt = '0;
                  state_nxt     = ISSUE;
                  slot_nxt      = '0;
                  idx_nxt       = start_ptr;
               end else begin
                  frame_cnt_nxt = frame_cnt + 3'd1;
               end
            end
         end
         ISSUE: begin
            if (abort) begin
               state_nxt = IDLE;
               if (!enable) frame_cnt_nxt = '0;
            end else begin
               if (alive[idx]) begin
                  timer_done_nxt[idx] = 1'b1;
                  random_nxt          = lfsr[3:0];
               end
               idx_nxt  = (idx == LAST) ? '0 : idx + ONE;
               slot_nxt = slot + ONE;
               if (slot == LAST) state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            if (abort) begin
               if (!enable) frame_cnt_nxt = '0;
            end else begin
               start_ptr_nxt   = (start_ptr == LAST) ? '0 : start_ptr + ONE;
               round_count_nxt = round_count + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_enemy_move_scheduler.sv
// tb_enemy_move_scheduler
//   Applies directed per-cycle vectors and compares timer_done, round_active,
//   round_count and random after every clock. Expected random values come
//   from an LFSR reference model. A hand-written sequence covers
//   asynchronous reset in the middle of a round.
module tb_enemy_move_scheduler;

   logic       CLK;
   logic       RESETn;
   logic       frame_start;
   logic       enable;
   logic       freeze;
   logic [1:0] level;
   logic [3:0] alive;
   logic [3:0] timer_done;
   logic [3:0] random;
   logic       round_active;
   logic [7:0] round_count;

   int unsigned n_checks;
   int unsigned n_errors;
   logic [3:0]  exp_rand;

   logic [15:0] m_lfsr;
   logic [15:0] m_prev;

   typedef struct {
      logic       fs;
      logic       en;
      logic       frz;
      logic [1:0] lvl;
      logic [3:0] al;
      logic [3:0] td;
      logic       act;
      logic [7:0] rc;
   } vec_t;

   vec_t vecs[$];

   enemy_move_scheduler #(
      .N_ENEMIES (4),
      .DIV_BASE  (6),
      .LFSR_SEED (16'hACE1)
   ) dut (
      .CLK          (CLK),
      .RESETn       (RESETn),
      .frame_start  (frame_start),
      .enable       (enable),
      .freeze       (freeze),
      .level        (level),
      .alive        (alive),
      .timer_done   (timer_done),
      .random       (random),
      .round_active (round_active),
      .round_count  (round_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference LFSR; m_prev holds the value of the cycle that just ended.
   always @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         m_lfsr <= 16'hACE1;
         m_prev <= 16'hACE1;
      end else begin
         m_prev <= m_lfsr;
         if (enable)
            m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic add(input logic fs, input logic en, input logic frz, input logic [1:0] lvl,
                      input logic [3:0] al, input logic [3:0] td, input logic act,
                      input logic [7:0] rc);
      vec_t v;
      v.fs = fs; v.en = en; v.frz = frz; v.lvl = lvl;
      v.al = al; v.td = td; v.act = act; v.rc = rc;
      vecs.push_back(v);
   endtask

   // n counted frames that do not complete the period
   task automatic add_frames(input int n, input logic [1:0] lvl, input logic [3:0] al,
                             input logic [7:0] rc);
      for (int i = 0; i < n; i++) add(1'b1, 1'b1, 1'b0, lvl, al, 4'h0, 1'b0, rc);
   endtask

   // Period-completing frame, four issue cycles, then the done cycle
   task automatic add_round(input logic [1:0] lvl, input logic [3:0] al,
                            input logic [3:0] t0, input logic [3:0] t1,
                            input logic [3:0] t2, input logic [3:0] t3,
                            input logic [7:0] rc, input logic fs_issue);
      add(1'b1, 1'b1, 1'b0, lvl, al, 4'h0, 1'b1, rc);
      add(fs_issue, 1'b1, 1'b0, lvl, al, t0, 1'b1, rc);
      add(fs_issue, 1'b1, 1'b0, lvl, al, t1, 1'b1, rc);
      add(fs_issue, 1'b1, 1'b0, lvl, al, t2, 1'b1, rc);
      add(fs_issue, 1'b1, 1'b0, lvl, al, t3, 1'b1, rc);
      add(1'b0, 1'b1, 1'b0, lvl, al, 4'h0, 1'b0, rc + 8'd1);
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      frame_start = v.fs;
      enable      = v.en;
      freeze      = v.frz;
      level       = v.lvl;
      alive       = v.al;
      @(negedge CLK);
      check({tag, ".timer_done"},   32'(timer_done),   32'(v.td));
      check({tag, ".round_active"}, 32'(round_active), 32'(v.act));
      check({tag, ".round_count"},  32'(round_count),  32'(v.rc));
      if (v.td != 4'h0) exp_rand = m_prev[3:0];
      check({tag, ".random"},       32'(random),       32'(exp_rand));
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      exp_rand    = 4'h0;
      RESETn      = 1'b0;
      frame_start = 1'b0;
      enable      = 1'b0;
      freeze      = 1'b0;
      level       = 2'd0;
      alive       = 4'h0;

      // 1: basic round, level 0, all alive
      add_frames(5, 2'd0, 4'hF, 8'd0);
      add_round(2'd0, 4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 8'd0, 1'b0);
      // 2: rotation starts at enemy 1; enemy 2 dead
      add_frames(5, 2'd0, 4'hB, 8'd1);
      add_round(2'd0, 4'hB, 4'h2, 4'h0, 4'h8, 4'h1, 8'd1, 1'b0);
      // 3: level 3 gives period 3; frame_start during issue is ignored
      add_frames(2, 2'd3, 4'hF, 8'd2);
      add_round(2'd3, 4'hF, 4'h4, 4'h8, 4'h1, 4'h2, 8'd2, 1'b0);
      add_frames(2, 2'd3, 4'hF, 8'd3);
      add_round(2'd3, 4'hF, 4'h8, 4'h1, 4'h2, 4'h4, 8'd3, 1'b1);
      //    frame_cnt reaches 4 at level 0; level 3 on the next frame starts a round
      add_frames(4, 2'd0, 4'hF, 8'd4);
      add_round(2'd3, 4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 8'd4, 1'b0);
      // 4: a frame seen under freeze is not counted; freeze in slot 1 aborts the round
      add_frames(3, 2'd0, 4'hF, 8'd5);
      add(1'b1, 1'b1, 1'b1, 2'd0, 4'hF, 4'h0, 1'b0, 8'd5);
      add_frames(2, 2'd0, 4'hF, 8'd5);
      add(1'b1, 1'b1, 1'b0, 2'd0, 4'hF, 4'h0, 1'b1, 8'd5);
      add(1'b0, 1'b1, 1'b0, 2'd0, 4'hF, 4'h2, 1'b1, 8'd5);
      add(1'b0, 1'b1, 1'b1, 2'd0, 4'hF, 4'h0, 1'b0, 8'd5);
      add(1'b0, 1'b1, 1'b1, 2'd0, 4'hF, 4'h0, 1'b0, 8'd5);
      add_frames(5, 2'd0, 4'hF, 8'd5);
      add_round(2'd0, 4'hF, 4'h2, 4'h4, 4'h8, 4'h1, 8'd5, 1'b0);
      // 5: enable low in slot 1 aborts; LFSR holds while disabled
      add_frames(5, 2'd0, 4'hF, 8'd6);
      add(1'b1, 1'b1, 1'b0, 2'd0, 4'hF, 4'h0, 1'b1, 8'd6);
      add(1'b0, 1'b1, 1'b0, 2'd0, 4'hF, 4'h4, 1'b1, 8'd6);
      add(1'b0, 1'b0, 1'b0, 2'd0, 4'hF, 4'h0, 1'b0, 8'd6);
      add(1'b1, 1'b0, 1'b0, 2'd0, 4'hF, 4'h0, 1'b0, 8'd6);
      add(1'b0, 1'b0, 1'b0, 2'd0, 4'hF, 4'h0, 1'b0, 8'd6);
      add(1'b0, 1'b0, 1'b0, 2'd0, 4'hF, 4'h0, 1'b0, 8'd6);
      add_frames(5, 2'd0, 4'hF, 8'd6);
      add_round(2'd0, 4'hF, 4'h4, 4'h8, 4'h1, 4'h2, 8'd6, 1'b0);

      // reset state
      @(negedge CLK);
      @(negedge CLK);
      check("reset.timer_done",   32'(timer_done),   32'h0);
      check("reset.random",       32'(random),       32'h0);
      check("reset.round_active", 32'(round_active), 32'h0);
      check("reset.round_count",  32'(round_count),  32'h0);
      RESETn = 1'b1;

      for (int unsigned i = 0; i < vecs.size(); i++)
         apply_vec(vecs[i], $sformatf("v%0d", i));

      // 6: asynchronous reset in the middle of a round (start_ptr is 3 here)
      vecs.delete();
      add_frames(5, 2'd0, 4'hF, 8'd7);
      add(1'b1, 1'b1, 1'b0, 2'd0, 4'hF, 4'h0, 1'b1, 8'd7);
      add(1'b0, 1'b1, 1'b0, 2'd0, 4'hF, 4'h8, 1'b1, 8'd7);
      for (int unsigned i = 0; i < vecs.size(); i++)
         apply_vec(vecs[i], $sformatf("r%0d", i));
      #2 RESETn = 1'b0;
      #1;
      check("async.timer_done",   32'(timer_done),   32'h0);
      check("async.random",       32'(random),       32'h0);
      check("async.round_active", 32'(round_active), 32'h0);
      check("async.round_count",  32'(round_count),  32'h0);
      exp_rand = 4'h0;
      @(negedge CLK);
      frame_start = 1'b0;
      RESETn      = 1'b1;

      // Six fresh frames are needed, and the round starts at enemy 0
      vecs.delete();
      add(1'b0, 1'b1, 1'b0, 2'd0, 4'hF, 4'h0, 1'b0, 8'd0);
      add_frames(5, 2'd0, 4'hF, 8'd0);
      add_round(2'd0, 4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 8'd0, 1'b0);
      for (int unsigned i = 0; i < vecs.size(); i++)
         apply_vec(vecs[i], $sformatf("p%0d", i));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
